// File: rtl/fast_square_step_scheduler.sv
// Frequency-step scheduler: pulses the synthesizer, blanks through settling, then qualifies PLL lock.
// Define FAST_SQUARE_PLL_RETRY_EN to re-pulse on lock timeout (up to MAX_RETRIES) before faulting.
module fast_square_step_scheduler #(
    parameter int NUM_FREQ_STEPS = 32,
    parameter int PULSE_TICKS    = 10,
    parameter int SETTLE_TICKS   = 640,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       step_req,
    input  logic       sweep_reset,
    input  logic       pll_locked,
    output logic       synth_step,
    output logic       step_ready,
    output logic [7:0] step_index,
    output logic       busy,
    output logic       lock_fault,
    output logic       overrun,
    output logic [3:0] debug
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PULSE     = 3'd1,
        SETTLE    = 3'd2,
        WAIT_LOCK = 3'd3,
        READY     = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [19:0] PULSE_LAST  = 20'(PULSE_TICKS - 1);
    localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_TICKS - 1);
    localparam logic [19:0] TMO_LAST    = 20'(LOCK_TIMEOUT - 1);
    localparam logic [7:0]  IDX_LAST    = 8'(NUM_FREQ_STEPS - 1);
    localparam logic [4:0]  LOCK_LAST   = 5'd15;

    state_t      state_reg, state_next;
    logic [19:0] phase_cnt_reg, phase_cnt_next;
    logic [4:0]  lock_cnt_reg, lock_cnt_next;
    logic [19:0] tmo_cnt_reg, tmo_cnt_next;
    logic [7:0]  step_index_reg, step_index_next;
    logic        first_req_reg, first_req_next;
    logic        overrun_reg, overrun_next;
    logic        lock_fault_reg, lock_fault_next;
    logic [1:0]  sync_reg;
    logic        pll_sync;
    logic        lock_hit;
    logic        tmo_hit;
    logic        retry_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pll_locked};
        end
    end

    assign pll_sync = sync_reg[1];
    // Sixteenth consecutive locked sample, checked against the timeout in the same cycle.
    assign lock_hit = pll_sync && (lock_cnt_reg == LOCK_LAST);
    assign tmo_hit  = (tmo_cnt_reg >= TMO_LAST);

`ifdef FAST_SQUARE_PLL_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    logic [RETRY_W-1:0] retry_cnt_reg, retry_cnt_next;

    assign retry_ok = (retry_cnt_reg < RETRY_LIMIT);

    always_comb begin
        retry_cnt_next = retry_cnt_reg;
        if (sweep_reset || state_reg == READY) begin
            retry_cnt_next = '0;
        end else if (state_reg == WAIT_LOCK && !lock_hit && tmo_hit && retry_ok) begin
            retry_cnt_next = retry_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            retry_cnt_reg <= '0;
        end else begin
            retry_cnt_reg <= retry_cnt_next;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            phase_cnt_reg  <= '0;
            lock_cnt_reg   <= '0;
            tmo_cnt_reg    <= '0;
            step_index_reg <= '0;
            first_req_reg  <= 1'b1;
            overrun_reg    <= 1'b0;
            lock_fault_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_cnt_reg  <= phase_cnt_next;
            lock_cnt_reg   <= lock_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            step_index_reg <= step_index_next;
            first_req_reg  <= first_req_next;
            overrun_reg    <= overrun_next;
            lock_fault_reg <= lock_fault_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_cnt_next  = '0;
        lock_cnt_next   = lock_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        step_index_next = step_index_reg;
        first_req_next  = first_req_reg;
        overrun_next    = overrun_reg;
        lock_fault_next = lock_fault_reg;

        if (sweep_reset) begin
            // Any coincident step_req is discarded here, so it never reaches overrun.
            state_next      = IDLE;
            lock_cnt_next   = '0;
            tmo_cnt_next    = '0;
            step_index_next = '0;
            first_req_next  = 1'b1;
            overrun_next    = 1'b0;
            lock_fault_next = 1'b0;
        end else begin
            if (step_req && state_reg != IDLE && state_reg != FAULT) begin
                overrun_next = 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (step_req) begin
                        state_next     = PULSE;
                        first_req_next = 1'b0;
                        if (first_req_reg || step_index_reg >= IDX_LAST) begin
                            step_index_next = '0;
                        end else begin
                            step_index_next = step_index_reg + 8'd1;
                        end
                    end
                end
                PULSE: begin
                    if (phase_cnt_reg >= PULSE_LAST) begin
                        state_next = SETTLE;
                    end else begin
                        phase_cnt_next = phase_cnt_reg + 20'd1;
                    end
                end
                SETTLE: begin
                    if (phase_cnt_reg >= SETTLE_LAST) begin
                        state_next    = WAIT_LOCK;
                        lock_cnt_next = '0;
                        tmo_cnt_next  = '0;
                    end else begin
                        phase_cnt_next = phase_cnt_reg + 20'd1;
                    end
                end
                WAIT_LOCK: begin
                    lock_cnt_next = pll_sync ? (lock_cnt_reg + 5'd1) : 5'd0;
                    tmo_cnt_next  = tmo_cnt_reg + 20'd1;
                    if (lock_hit) begin
                        state_next = READY;
                    end else if (tmo_hit) begin
                        if (retry_ok) begin
                            state_next = PULSE;
                        end else begin
                            state_next      = FAULT;
                            lock_fault_next = 1'b1;
                        end
                    end
                end
                READY: begin
                    state_next = IDLE;
                end
                FAULT: begin
                    lock_fault_next = 1'b1;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign synth_step = (state_reg == PULSE);
    assign step_ready = (state_reg == READY);
    assign busy       = (state_reg != IDLE);
    assign step_index = step_index_reg;
    assign lock_fault = lock_fault_reg;
    assign overrun    = overrun_reg;
    assign debug      = {lock_fault_reg, state_reg};

endmodule
